hls_perf_monitor: RTL and testbench

- Synthesizable, multi-channel performance monitor for HLS ap_ctrl_chain blocks.
- Observes N start/ready/done/continue handshakes, classifies each channel cycle as idle, busy or stalled, and accumulates per-channel statistics.
- Statistics are invocations, busy/stall cycles, and last/min/max latency. They are readable through a registered request/valid port.
- Sits beside the kernel top level, so the same counts are available on silicon as well as in co-simulation.

---
 rtl/hls_perf_pkg.sv | 32 +++
 rtl/hls_perf_channel.sv | 121 ++++++++++++
 rtl/hls_perf_monitor.sv | 103 ++++++++++
 tb/tb_hls_perf_monitor.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_perf_pkg.sv
// Shared types and helpers for the HLS handshake performance monitor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hls_perf_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    WAIT_CONT = 2'd2
  } ch_state_e;

  typedef enum logic [2:0] {
    SEL_INV   = 3'd0,
    SEL_BUSY  = 3'd1,
    SEL_STALL = 3'd2,
    SEL_LAST  = 3'd3,
    SEL_MIN   = 3'd4,
    SEL_MAX   = 3'd5,
    SEL_STAT  = 3'd6,
    SEL_ZERO  = 3'd7
  } rd_sel_e;

  // min_lat starts at all-ones so the first completion always replaces it;
  // callers truncate to their counter width
  localparam logic [63:0] MIN_INIT = '1;

  // Increment that sticks at maxv instead of wrapping
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] maxv);
    return (v >= maxv) ? maxv : v + 64'd1;
  endfunction

endpackage

// File: rtl/hls_perf_channel.sv
// One ap_ctrl_chain handshake tracker with its six saturating statistics.
// Latency: statistics and state update on the clock edge after the observed cycle.
// Backpressure: none; purely observes start/done/continue and never stalls them.
module hls_perf_channel
  import hls_perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             upd,
  input  logic             clear,
  input  logic             start,
  input  logic             done,
  input  logic             cont,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic             ovf,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), 64'(CMAX)));
  endfunction

  ch_state_e        cur, nxt;
  logic [CNT_W-1:0] lat_cnt, lat_nxt, latency;
  logic             accept, complete, busy_ev, stall_ev;

  assign state    = cur;
  assign busy_ev  = (cur == BUSY) | accept;
  assign stall_ev = (cur == WAIT_CONT) & ~cont;

  // Handshake state and running latency counter; clear deliberately leaves both alone
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur     <= IDLE;
      lat_cnt <= '0;
    end else begin
      cur     <= nxt;
      lat_cnt <= lat_nxt;
    end
  end

  // Next state, start acceptance, completion detection and the completed latency
  always_comb begin
    nxt      = cur;
    lat_nxt  = lat_cnt;
    accept   = 1'b0;
    complete = 1'b0;
    latency  = CNT_W'(1);
    case (cur)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (done) begin
            complete = 1'b1;
            nxt      = cont ? IDLE : WAIT_CONT;
          end else begin
            nxt     = BUSY;
            lat_nxt = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (done) begin
          complete = 1'b1;
          latency  = inc(lat_cnt);
          nxt      = cont ? IDLE : WAIT_CONT;
        end else begin
          lat_nxt = inc(lat_cnt);
        end
      end
      WAIT_CONT: begin
        // a start seen together with continue is left for the next IDLE cycle
        if (cont) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Statistics: clear beats any same-cycle update; overflow marks the first clipped increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inv_cnt   <= '0;
      busy_cnt  <= '0;
      stall_cnt <= '0;
      last_lat  <= '0;
      min_lat   <= CNT_W'(MIN_INIT);
      max_lat   <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      inv_cnt   <= '0;
      busy_cnt  <= '0;
      stall_cnt <= '0;
      last_lat  <= '0;
      min_lat   <= CNT_W'(MIN_INIT);
      max_lat   <= '0;
      ovf       <= 1'b0;
    end else if (upd) begin
      if (complete) begin
        inv_cnt  <= inc(inv_cnt);
        last_lat <= latency;
        if (latency < min_lat) min_lat <= latency;
        if (latency > max_lat) max_lat <= latency;
      end
      if (busy_ev)  busy_cnt  <= inc(busy_cnt);
      if (stall_ev) stall_cnt <= inc(stall_cnt);
      if ((complete & (inv_cnt == CMAX)) | (busy_ev & (busy_cnt == CMAX)) |
          (stall_ev & (stall_cnt == CMAX)))
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/hls_perf_monitor.sv
// Multi-channel ap_ctrl_chain performance monitor with a registered statistics read port.
// Latency: rd_valid/rd_data/rd_err one cycle after rd_req, carrying the pre-update value.
// Backpressure: none; one read accepted every cycle, handshakes are observed only.
module hls_perf_monitor
  import hls_perf_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_continue,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic              frozen,
  output logic [NUM_CH-1:0] overflow
);

  logic [CNT_W-1:0] inv_a   [NUM_CH];
  logic [CNT_W-1:0] busy_a  [NUM_CH];
  logic [CNT_W-1:0] stall_a [NUM_CH];
  logic [CNT_W-1:0] last_a  [NUM_CH];
  logic [CNT_W-1:0] min_a   [NUM_CH];
  logic [CNT_W-1:0] max_a   [NUM_CH];
  logic [1:0]       state_a [NUM_CH];
  logic [CNT_W-1:0] mux_dat;
  logic             ch_err;
  logic             upd;

  // frozen only gates accumulation, so increments in the cycle finish is first seen still land
  assign upd    = enable & ~frozen & ~clear;
  assign ch_err = 32'(rd_ch) >= 32'(NUM_CH);

  // Sticky end-of-run flag; clear wins over a coincident finish
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       frozen <= 1'b0;
    else if (clear)  frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hls_perf_channel #(.CNT_W(CNT_W)) u_ch (
      .clock     (clock),
      .reset     (reset),
      .upd       (upd),
      .clear     (clear),
      .start     (ch_start[g]),
      .done      (ch_done[g]),
      .cont      (ch_continue[g]),
      .inv_cnt   (inv_a[g]),
      .busy_cnt  (busy_a[g]),
      .stall_cnt (stall_a[g]),
      .last_lat  (last_a[g]),
      .min_lat   (min_a[g]),
      .max_lat   (max_a[g]),
      .ovf       (overflow[g]),
      .state     (state_a[g])
    );
  end

  // Select the requested statistic from the currently registered channel values
  always_comb begin
    mux_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(rd_ch) == 32'(i)) begin
        case (rd_sel_e'(rd_sel))
          SEL_INV:   mux_dat = inv_a[i];
          SEL_BUSY:  mux_dat = busy_a[i];
          SEL_STALL: mux_dat = stall_a[i];
          SEL_LAST:  mux_dat = last_a[i];
          SEL_MIN:   mux_dat = min_a[i];
          SEL_MAX:   mux_dat = max_a[i];
          SEL_STAT:  mux_dat = CNT_W'({overflow[i], state_a[i]});
          default:   mux_dat = '0;
        endcase
      end
    end
  end

  // Registered read response; data holds between reads, err only accompanies valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req & ch_err;
      if (rd_req) rd_data <= ch_err ? '0 : mux_dat;
    end
  end

endmodule

// File: tb/tb_hls_perf_monitor.sv
module tb_hls_perf_monitor;

  localparam int NCH  = 8;
  localparam int W    = 16;
  localparam int WS   = 4;
  localparam int CW   = 4;
  localparam int MAXV = 65535;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           enable, clear, finish;
  logic [NCH-1:0] ch_start, ch_done, ch_continue;
  logic           rd_req;
  logic [CW-1:0]  rd_ch;
  logic [2:0]     rd_sel;

  logic           rd_valid_m, rd_err_m, frozen_m;
  logic [W-1:0]   rd_data_m;
  logic [NCH-1:0] overflow_m;
  logic           rd_valid_s, rd_err_s, frozen_s;
  logic [WS-1:0]  rd_data_s;
  logic [NCH-1:0] overflow_s;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model state (spec-level: in-flight flag, start timestamp, waiting flag)
  bit m_inflight [NCH];
  bit m_wait     [NCH];
  int m_t0       [NCH];
  int m_inv      [NCH];
  int m_busy     [NCH];
  int m_stall    [NCH];
  int m_last     [NCH];
  int m_min      [NCH];
  int m_max      [NCH];
  bit m_ovf      [NCH];
  bit m_frozen;

  always #5 clock = ~clock;

  hls_perf_monitor #(.NUM_CH(NCH), .CNT_W(W), .CH_W(CW)) dut_m (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
    .ch_start(ch_start), .ch_done(ch_done), .ch_continue(ch_continue),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid_m), .rd_data(rd_data_m), .rd_err(rd_err_m),
    .frozen(frozen_m), .overflow(overflow_m)
  );

  hls_perf_monitor #(.NUM_CH(NCH), .CNT_W(WS), .CH_W(CW)) dut_s (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
    .ch_start(ch_start), .ch_done(ch_done), .ch_continue(ch_continue),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid_s), .rd_data(rd_data_s), .rd_err(rd_err_s),
    .frozen(frozen_s), .overflow(overflow_s)
  );

  task automatic step();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic idle_inputs();
    enable      = 1'b1;
    clear       = 1'b0;
    finish      = 1'b0;
    ch_start    = '0;
    ch_done     = '0;
    ch_continue = '1;
    rd_req      = 1'b0;
    rd_ch       = '0;
    rd_sel      = '0;
  endtask

  task automatic cyc(input logic [NCH-1:0] s, input logic [NCH-1:0] d, input logic [NCH-1:0] c);
    ch_start    = s;
    ch_done     = d;
    ch_continue = c;
    step();
    ch_start    = '0;
    ch_done     = '0;
    ch_continue = '1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic rd(input int ch, input int sel, output logic [W-1:0] d, output logic e, output logic v);
    rd_req = 1'b1;
    rd_ch  = CW'(ch);
    rd_sel = 3'(sel);
    step();
    d      = rd_data_m;
    e      = rd_err_m;
    v      = rd_valid_m;
    rd_req = 1'b0;
  endtask

  function automatic int m_read(input int ch, input int sel);
    case (sel)
      0: return m_inv[ch];
      1: return m_busy[ch];
      2: return m_stall[ch];
      3: return m_last[ch];
      4: return m_min[ch];
      5: return m_max[ch];
      6: return (m_ovf[ch] ? 4 : 0) + (m_wait[ch] ? 2 : (m_inflight[ch] ? 1 : 0));
      default: return 0;
    endcase
  endfunction

  task automatic model_init();
    for (int i = 0; i < NCH; i++) begin
      m_inflight[i] = 0; m_wait[i] = 0; m_t0[i] = 0;
      m_inv[i] = 0; m_busy[i] = 0; m_stall[i] = 0;
      m_last[i] = 0; m_min[i] = MAXV; m_max[i] = 0; m_ovf[i] = 0;
    end
    m_frozen = 0;
  endtask

  // one clock of the spec's rules, applied to the inputs currently driven
  task automatic model_tick(input int now);
    bit upd, comp, bev, sev;
    int lat;
    upd = enable && !m_frozen && !clear;
    for (int i = 0; i < NCH; i++) begin
      comp = 0; bev = 0; sev = 0; lat = 0;
      if (m_wait[i]) begin
        if (!ch_continue[i]) sev = 1;
        else m_wait[i] = 0;
      end else if (m_inflight[i]) begin
        bev = 1;
        if (ch_done[i]) begin
          comp = 1; lat = now - m_t0[i] + 1;
          m_inflight[i] = 0; m_wait[i] = !ch_continue[i];
        end
      end else if (ch_start[i]) begin
        bev = 1;
        if (ch_done[i]) begin
          comp = 1; lat = 1; m_wait[i] = !ch_continue[i];
        end else begin
          m_inflight[i] = 1; m_t0[i] = now;
        end
      end
      if (lat > MAXV) lat = MAXV;
      if (clear) begin
        m_inv[i] = 0; m_busy[i] = 0; m_stall[i] = 0;
        m_last[i] = 0; m_min[i] = MAXV; m_max[i] = 0; m_ovf[i] = 0;
      end else if (upd) begin
        if (comp) begin
          if (m_inv[i] == MAXV) m_ovf[i] = 1; else m_inv[i]++;
          m_last[i] = lat;
          if (lat < m_min[i]) m_min[i] = lat;
          if (lat > m_max[i]) m_max[i] = lat;
        end
        if (bev) begin
          if (m_busy[i] == MAXV) m_ovf[i] = 1; else m_busy[i]++;
        end
        if (sev) begin
          if (m_stall[i] == MAXV) m_ovf[i] = 1; else m_stall[i]++;
        end
      end
    end
    if (clear) m_frozen = 0;
    else if (finish) m_frozen = 1;
  endtask

  task automatic test_reset();
    logic [W-1:0] d; logic e, v;
    idle_inputs();
    #1 reset = 1'b1;
    #3;
    checks++;
    if ({rd_valid_m, rd_err_m, frozen_m, overflow_m, rd_data_m} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b err=%0b frozen=%0b ovf=%h data=%h exp all 0",
               rd_valid_m, rd_err_m, frozen_m, overflow_m, rd_data_m);
    end
    @(negedge clock) reset = 1'b0;
    rd(0, 4, d, e, v);
    checks++;
    if (v !== 1'b1 || d !== 16'hFFFF) begin
      errors++; $display("FAIL reset_min got v=%0b d=%h exp v=1 d=ffff", v, d);
    end
    rd(0, 6, d, e, v);
    checks++;
    if (d !== 16'd0) begin errors++; $display("FAIL reset_state got %h exp 0", d); end
  endtask

  task automatic test_single_cycle();
    logic [W-1:0] d; logic e, v;
    int sels[5] = '{0, 3, 4, 5, 1};
    do_clear();
    cyc(8'h01, 8'h01, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      rd(0, sels[k], d, e, v);
      checks++;
      if (d !== 16'd1) begin errors++; $display("FAIL single_sel%0d got %0d exp 1", sels[k], d); end
    end
  endtask

  task automatic test_latency();
    logic [W-1:0] d; logic e, v;
    int exps[6] = '{2, 7, 0, 2, 2, 5};
    do_clear();
    cyc(8'h04, 8'h00, 8'hFF);
    repeat (3) cyc(8'h00, 8'h00, 8'hFF);
    cyc(8'h00, 8'h04, 8'hFF);
    repeat (10) cyc(8'h00, 8'h00, 8'hFF);
    cyc(8'h04, 8'h00, 8'hFF);
    cyc(8'h00, 8'h04, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      rd(2, k, d, e, v);
      checks++;
      if (d !== W'(exps[k])) begin errors++; $display("FAIL latency_sel%0d got %0d exp %0d", k, d, exps[k]); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d; logic e, v;
    do_clear();
    cyc(8'h02, 8'h02, ~8'h02);
    ch_continue = ~8'h02;
    rd(1, 6, d, e, v);
    checks++;
    if (d !== 16'd2) begin errors++; $display("FAIL stall_state_wait got %0d exp 2", d); end
    cyc(8'h00, 8'h00, ~8'h02);
    cyc(8'h00, 8'h00, ~8'h02);
    rd(1, 2, d, e, v);
    checks++;
    if (d !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", d); end
    rd(1, 6, d, e, v);
    checks++;
    if (d !== 16'd0) begin errors++; $display("FAIL stall_state_idle got %0d exp 0", d); end
    rd(1, 0, d, e, v);
    checks++;
    if (d !== 16'd1) begin errors++; $display("FAIL stall_inv got %0d exp 1", d); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] d; logic e, v;
    do_clear();
    repeat (20) cyc(8'h08, 8'h08, 8'hFF);
    rd(3, 0, d, e, v);
    checks++;
    if (rd_data_s !== 4'd15) begin errors++; $display("FAIL sat_inv_small got %0d exp 15", rd_data_s); end
    checks++;
    if (d !== 16'd20) begin errors++; $display("FAIL sat_inv_wide got %0d exp 20", d); end
    checks++;
    if (overflow_s !== 8'h08) begin errors++; $display("FAIL sat_ovf_small got %h exp 08", overflow_s); end
    checks++;
    if (overflow_m !== 8'h00) begin errors++; $display("FAIL sat_ovf_wide got %h exp 00", overflow_m); end
  endtask

  task automatic test_freeze_clear();
    logic [W-1:0] d; logic e, v;
    int t_start, t_done, lat;
    do_clear();
    t_start = cyc_n;
    cyc(8'h10, 8'h00, 8'hFF);
    finish = 1'b1;
    cyc(8'h00, 8'h00, 8'hFF);
    finish = 1'b0;
    checks++;
    if (frozen_m !== 1'b1) begin errors++; $display("FAIL freeze_set got %0b exp 1", frozen_m); end
    repeat (2) cyc(8'h00, 8'h00, 8'hFF);
    rd(4, 1, d, e, v);
    checks++;
    if (d !== 16'd2) begin errors++; $display("FAIL freeze_busy_hold got %0d exp 2", d); end
    rd(4, 0, d, e, v);
    checks++;
    if (d !== 16'd0 || frozen_m !== 1'b1) begin
      errors++; $display("FAIL freeze_inv_hold got inv=%0d frozen=%0b exp inv=0 frozen=1", d, frozen_m);
    end
    clear = 1'b1; finish = 1'b1;
    step();
    clear = 1'b0; finish = 1'b0;
    checks++;
    if (frozen_m !== 1'b0) begin errors++; $display("FAIL clear_beats_finish got %0b exp 0", frozen_m); end
    t_done = cyc_n;
    cyc(8'h00, 8'h10, 8'hFF);
    lat = t_done - t_start + 1;
    for (int k = 3; k <= 5; k++) begin
      rd(4, k, d, e, v);
      checks++;
      if (d !== W'(lat)) begin errors++; $display("FAIL inflight_lat_sel%0d got %0d exp %0d", k, d, lat); end
    end
    rd(4, 1, d, e, v);
    checks++;
    if (d !== 16'd1) begin errors++; $display("FAIL post_clear_busy got %0d exp 1", d); end
  endtask

  task automatic test_read_port();
    logic [W-1:0] d; logic e, v;
    rd(9, 0, d, e, v);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 16'd0) begin
      errors++; $display("FAIL rd_bad_ch got v=%0b e=%0b d=%0d exp v=1 e=1 d=0", v, e, d);
    end
    step();
    checks++;
    if (rd_valid_m !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %0b exp 0", rd_valid_m); end
    do_clear();
    cyc(8'h01, 8'h01, 8'hFF);
    ch_start = 8'h01; ch_done = 8'h01;
    rd(0, 0, d, e, v);
    ch_start = 8'h00; ch_done = 8'h00;
    checks++;
    if (d !== 16'd1 || e !== 1'b0) begin errors++; $display("FAIL rd_pre_update got d=%0d e=%0b exp d=1 e=0", d, e); end
    rd(0, 0, d, e, v);
    checks++;
    if (d !== 16'd2) begin errors++; $display("FAIL rd_post_update got %0d exp 2", d); end
    rd(0, 7, d, e, v);
    checks++;
    if (d !== 16'd0 || v !== 1'b1) begin errors++; $display("FAIL rd_sel7 got d=%0d v=%0b exp d=0 v=1", d, v); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] d; logic e, v;
    repeat (20) cyc(8'h08, 8'h08, 8'hFF);
    cyc(8'h20, 8'h00, 8'hFF);
    cyc(8'h00, 8'h00, 8'hFF);
    finish = 1'b1;
    rd(0, 4, d, e, v);
    finish = 1'b0;
    checks++;
    if (frozen_m !== 1'b1 || rd_valid_m !== 1'b1 || overflow_s === 8'h00) begin
      errors++; $display("FAIL prereset_setup got frozen=%0b valid=%0b ovf_s=%h exp 1 1 nonzero",
                         frozen_m, rd_valid_m, overflow_s);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rd_valid_m, rd_err_m, frozen_m, overflow_m, rd_data_m} !== '0 ||
        {rd_valid_s, rd_err_s, frozen_s, overflow_s, rd_data_s} !== '0) begin
      errors++; $display("FAIL async_reset got m=%0b%0b%0b %h %h s=%0b%0b%0b %h %h exp all 0",
                         rd_valid_m, rd_err_m, frozen_m, overflow_m, rd_data_m,
                         rd_valid_s, rd_err_s, frozen_s, overflow_s, rd_data_s);
    end
    #2 reset = 1'b0;
    rd(5, 6, d, e, v);
    checks++;
    if (d !== 16'd0) begin errors++; $display("FAIL abandon_state got %0d exp 0", d); end
    rd(5, 0, d, e, v);
    checks++;
    if (d !== 16'd0) begin errors++; $display("FAIL abandon_inv got %0d exp 0", d); end
    rd(5, 4, d, e, v);
    checks++;
    if (d !== 16'hFFFF) begin errors++; $display("FAIL abandon_min got %h exp ffff", d); end
  endtask

  task automatic test_random();
    bit exp_v, exp_e;
    int exp_d;
    logic [NCH-1:0] exp_ovf;
    idle_inputs();
    step();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    model_init();
    for (int n = 0; n < 3000; n++) begin
      ch_start    = NCH'($urandom) & NCH'($urandom);
      ch_done     = NCH'($urandom) & NCH'($urandom);
      ch_continue = NCH'($urandom) | NCH'($urandom);
      enable      = ($urandom_range(0, 7) != 0);
      clear       = ($urandom_range(0, 63) == 0);
      finish      = ($urandom_range(0, 127) == 0);
      rd_req      = ($urandom_range(0, 1) != 0);
      rd_ch       = CW'($urandom_range(0, 9));
      rd_sel      = 3'($urandom_range(0, 7));
      exp_v = rd_req;
      exp_e = rd_req && (int'(rd_ch) >= NCH);
      exp_d = exp_e ? 0 : m_read(int'(rd_ch), int'(rd_sel));
      model_tick(n);
      step();
      checks++;
      if (rd_valid_m !== exp_v) begin
        errors++; $display("FAIL rand_valid n=%0d got %0b exp %0b", n, rd_valid_m, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (rd_err_m !== exp_e || rd_data_m !== W'(exp_d)) begin
          errors++; $display("FAIL rand_read n=%0d got err=%0b data=%0d exp err=%0b data=%0d",
                             n, rd_err_m, rd_data_m, exp_e, exp_d);
        end
      end
      for (int i = 0; i < NCH; i++) exp_ovf[i] = m_ovf[i];
      checks++;
      if (frozen_m !== m_frozen || overflow_m !== exp_ovf) begin
        errors++; $display("FAIL rand_flags n=%0d got frozen=%0b ovf=%h exp frozen=%0b ovf=%h",
                           n, frozen_m, overflow_m, m_frozen, exp_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_latency();
    test_stall();
    test_saturation();
    test_freeze_clear();
    test_read_port();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
